// File: rtl/move_request_scheduler_if.sv
// Move-request bus between the button front end / game2048 and the scheduler.
interface move_request_scheduler_if;
  logic [3:0]  btn_raw;
  logic [1:0]  game_state;
  logic [3:0]  direction;
  logic        busy;
  logic [15:0] move_count;
  logic        ack_timeout;

  // Side that supplies buttons and game state and observes the request.
  modport master (
    output btn_raw,
    output game_state,
    input  direction,
    input  busy,
    input  move_count,
    input  ack_timeout
  );

  // Scheduler side.
  modport slave (
    input  btn_raw,
    input  game_state,
    output direction,
    output busy,
    output move_count,
    output ack_timeout
  );
endinterface

// File: rtl/move_request_scheduler.sv
// Debounces four direction buttons and issues one prioritised one-hot move per press to game2048.
module move_request_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned ACK_TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  move_request_scheduler_if.slave   bus
);

  localparam int unsigned NBTN = 4;
  localparam int unsigned DCW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned TCW  = $clog2(ACK_TIMEOUT);
  localparam int unsigned CNTW = 16;

  typedef enum logic [2:0] {
    WAIT_READY,
    RELEASE,
    ARMED,
    ISSUE,
    WAIT_IDLE,
    HALT
  } state_t;

  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] deb_q;
  logic [DCW-1:0]  dcnt_q [NBTN];

  state_t          state_q, state_d;
  logic [NBTN-1:0] dir_q, dir_d;
  logic            busy_q, busy_d;
  logic [TCW-1:0]  timer_q, timer_d;
  logic [CNTW-1:0] move_count_q, move_count_d;
  logic            to_q, to_d;

  logic            playing;
  logic            game_over;

  assign playing   = (bus.game_state == 2'b01);
  assign game_over = bus.game_state[1];

  // Top beats bottom beats left beats right.
  function automatic logic [NBTN-1:0] prio_onehot(input logic [NBTN-1:0] v);
    logic [NBTN-1:0] r;
    r = '0;
    if (v[0])      r = 4'b0001;
    else if (v[1]) r = 4'b0010;
    else if (v[2]) r = 4'b0100;
    else if (v[3]) r = 4'b1000;
    return r;
  endfunction

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button debounce: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= '0;
      for (int i = 0; i < NBTN; i++) dcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DCW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i]  <= sync2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + DCW'(1);
        end
      end
    end
  end

  // Next-state and next-output logic for the move sequencer.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    timer_d      = timer_q;
    move_count_d = move_count_q;
    to_d         = to_q;
    unique case (state_q)
      WAIT_READY: begin
        dir_d = '0;
        if (game_over)    state_d = HALT;
        else if (playing) state_d = RELEASE;
      end
      RELEASE: begin
        dir_d = '0;
        if (game_over)        state_d = HALT;
        else if (deb_q == '0) state_d = ARMED;
      end
      ARMED: begin
        dir_d   = '0;
        timer_d = '0;
        if (game_over)     state_d = HALT;
        else if (!playing) state_d = WAIT_READY;
        else if (|deb_q) begin
          state_d = ISSUE;
          dir_d   = prio_onehot(deb_q);
        end
      end
      ISSUE: begin
        timer_d = timer_q + TCW'(1);
        // Leaving the playing state is the acknowledge; it takes precedence over timeout.
        if (!playing) begin
          dir_d        = '0;
          move_count_d = move_count_q + CNTW'(1);
          state_d      = WAIT_IDLE;
        end else if (timer_q == TCW'(ACK_TIMEOUT - 1)) begin
          dir_d   = '0;
          to_d    = 1'b1;
          state_d = RELEASE;
        end
      end
      WAIT_IDLE: begin
        dir_d = '0;
        if (game_over)    state_d = HALT;
        else if (playing) state_d = RELEASE;
      end
      HALT: begin
        dir_d = '0;
        if (bus.game_state == 2'b00) state_d = WAIT_READY;
      end
      default: begin
        dir_d   = '0;
        state_d = WAIT_READY;
      end
    endcase
    busy_d = (state_d == ISSUE) || (state_d == WAIT_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= WAIT_READY;
      dir_q        <= '0;
      busy_q       <= 1'b0;
      timer_q      <= '0;
      move_count_q <= '0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
      move_count_q <= move_count_d;
      to_q         <= to_d;
    end
  end

  assign bus.direction   = dir_q;
  assign bus.busy        = busy_q;
  assign bus.move_count  = move_count_q;
  assign bus.ack_timeout = to_q;

endmodule

// File: tb/tb_move_request_scheduler.sv
// Directed, table-driven bench for move_request_scheduler with short debounce and timeout.
module tb_move_request_scheduler;

  localparam int unsigned DEB = 4;
  localparam int unsigned ACK = 8;

  logic clk = 1'b0;
  logic rst;

  move_request_scheduler_if bus ();

  move_request_scheduler #(
    .DEBOUNCE_CYCLES (DEB),
    .ACK_TIMEOUT     (ACK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic [1:0]  gs;
    int          cyc;
    logic [3:0]  dir;
    logic        busy;
    logic [15:0] cnt;
    logic        to;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  // Drive inputs at a falling edge, let cyc rising edges pass, return at the next falling edge.
  task automatic apply(input logic [3:0] btn, input logic [1:0] gs, input int cyc);
    bus.btn_raw    = btn;
    bus.game_state = gs;
    repeat (cyc) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [3:0] dir, input logic busy,
                            input logic [15:0] cnt, input logic to);
    n_cmp++;
    if ({bus.direction, bus.busy, bus.move_count, bus.ack_timeout} !== {dir, busy, cnt, to}) begin
      n_bad++;
      $display("FAIL %s: got dir=%b busy=%b cnt=%h to=%b, want dir=%b busy=%b cnt=%h to=%b",
               name, bus.direction, bus.busy, bus.move_count, bus.ack_timeout,
               dir, busy, cnt, to);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nz;
    logic [3:0] b;

    // btn, gs, cycles, dir, busy, count, timeout
    vecs[0]  = '{4'b0000, 2'b01, 10, 4'b0000, 1'b0, 16'd0, 1'b0}; // ready -> armed
    vecs[1]  = '{4'b0100, 2'b01, 10, 4'b0100, 1'b1, 16'd0, 1'b0}; // left issued
    vecs[2]  = '{4'b0100, 2'b00,  2, 4'b0000, 1'b1, 16'd1, 1'b0}; // ack
    vecs[3]  = '{4'b0100, 2'b01, 10, 4'b0000, 1'b0, 16'd1, 1'b0}; // held: no repeat
    vecs[4]  = '{4'b0000, 2'b01, 10, 4'b0000, 1'b0, 16'd1, 1'b0}; // released, armed
    vecs[5]  = '{4'b1100, 2'b01, 10, 4'b0100, 1'b1, 16'd1, 1'b0}; // left beats right
    vecs[6]  = '{4'b1100, 2'b00,  2, 4'b0000, 1'b1, 16'd2, 1'b0};
    vecs[7]  = '{4'b0000, 2'b01, 12, 4'b0000, 1'b0, 16'd2, 1'b0};
    vecs[8]  = '{4'b0011, 2'b01, 10, 4'b0001, 1'b1, 16'd2, 1'b0}; // top beats bottom
    vecs[9]  = '{4'b0011, 2'b00,  2, 4'b0000, 1'b1, 16'd3, 1'b0};
    vecs[10] = '{4'b0000, 2'b01, 12, 4'b0000, 1'b0, 16'd3, 1'b0};
    vecs[11] = '{4'b0001, 2'b01, 10, 4'b0001, 1'b1, 16'd3, 1'b0}; // top issued
    vecs[12] = '{4'b0001, 2'b11,  2, 4'b0000, 1'b0, 16'd4, 1'b0}; // lose acks, then HALT
    vecs[13] = '{4'b0010, 2'b11, 12, 4'b0000, 1'b0, 16'd4, 1'b0}; // presses ignored in HALT
    vecs[14] = '{4'b0000, 2'b00, 10, 4'b0000, 1'b0, 16'd4, 1'b0}; // restart
    vecs[15] = '{4'b0000, 2'b01, 10, 4'b0000, 1'b0, 16'd4, 1'b0};
    vecs[16] = '{4'b1000, 2'b01, 10, 4'b1000, 1'b1, 16'd4, 1'b0}; // moves resume
    vecs[17] = '{4'b1000, 2'b00,  2, 4'b0000, 1'b1, 16'd5, 1'b0};
    vecs[18] = '{4'b0000, 2'b01, 12, 4'b0000, 1'b0, 16'd5, 1'b0};

    // Reset with all buttons asserted.
    rst            = 1'b0;
    bus.btn_raw    = 4'b1111;
    bus.game_state = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_out("reset", 4'b0000, 1'b0, 16'd0, 1'b0);
    bus.btn_raw = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].btn, vecs[i].gs, vecs[i].cyc);
      expect_out($sformatf("vec%0d", i), vecs[i].dir, vecs[i].busy, vecs[i].cnt, vecs[i].to);
    end

    // Bounce on top: toggles every DEB/2 cycles never settle long enough.
    b = 4'b0000;
    for (int t = 0; t < 10; t++) begin
      b[0] = ~b[0];
      apply(b, 2'b01, DEB / 2);
      expect_out($sformatf("bounce%0d", t), 4'b0000, 1'b0, 16'd5, 1'b0);
    end
    apply(4'b0000, 2'b01, 10);
    expect_out("bounce_settled", 4'b0000, 1'b0, 16'd5, 1'b0);

    // Timeout: right held while still playing; count cycles with a live request.
    nz = 0;
    bus.btn_raw = 4'b1000;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.direction != 4'b0000) nz++;
      n_cmp++;
      if (bus.direction != 4'b0000 && bus.direction != 4'b1000) begin
        n_bad++;
        $display("FAIL timeout_dir: got %b, want 0000 or 1000", bus.direction);
      end
    end
    n_cmp++;
    if (nz != ACK) begin
      n_bad++;
      $display("FAIL timeout_len: got %0d cycles, want %0d", nz, ACK);
    end
    expect_out("timeout_flag", 4'b0000, 1'b0, 16'd5, 1'b1);
    apply(4'b0000, 2'b01, 12);
    apply(4'b1000, 2'b01, 10);
    expect_out("after_timeout_issue", 4'b1000, 1'b1, 16'd5, 1'b1);
    apply(4'b1000, 2'b00, 2);
    expect_out("after_timeout_ack", 4'b0000, 1'b1, 16'd6, 1'b1);
    apply(4'b0000, 2'b01, 12);
    expect_out("after_timeout_armed", 4'b0000, 1'b0, 16'd6, 1'b1);

    // Move counter wrap.
    force dut.move_count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.move_count_q;
    apply(4'b0100, 2'b01, 10);
    expect_out("wrap_issue", 4'b0100, 1'b1, 16'hFFFF, 1'b1);
    apply(4'b0100, 2'b00, 2);
    expect_out("wrap_ack", 4'b0000, 1'b1, 16'h0000, 1'b1);
    apply(4'b0000, 2'b01, 12);

    // Reset asserted while a request is live.
    apply(4'b0001, 2'b01, 10);
    expect_out("midmove_issue", 4'b0001, 1'b1, 16'h0000, 1'b1);
    rst = 1'b0;
    #1;
    expect_out("midmove_reset", 4'b0000, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    apply(4'b0001, 2'b00, 4);
    expect_out("post_reset_idle", 4'b0000, 1'b0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
